// File: rtl/mat_sq_seq_if.sv
// Load/result handshake bundle for mat_sq_seq: element stream in, result stream out,
// plus job control and status. The design sits on the slave side.
interface mat_sq_seq_if #(
  parameter int DATA_W = 26
);
  logic              start;
  logic              mode_sq;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              busy;
  logic              done;
  logic              ovf;

  modport slave (
    input  start, mode_sq, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, busy, done, ovf
  );

  modport master (
    output start, mode_sq, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy, done, ovf
  );
endinterface

// File: rtl/mat_sq_seq.sv
// Sequential NxN fixed-point matrix product (A*A or A*B), one MAC per cycle, N cycles per result,
// results held under out_ready backpressure. Define MAT_SQ_SAT_EN to saturate results and flag ovf.
module mat_sq_seq #(
  parameter int N      = 4,
  parameter int DATA_W = 26,
  parameter int FRAC_W = 13
) (
  input  logic          clk_mul,
  input  logic          rst_mul,
  mat_sq_seq_if.slave   bus
);

  localparam int IW    = $clog2(N);
  localparam int NN    = N * N;
  localparam int AW    = $clog2(NN);
  localparam int LW    = $clog2(2 * NN);
  localparam int PW    = 2 * DATA_W;
  localparam int ACC_W = PW + $clog2(N);
  localparam int HI_W  = ACC_W - FRAC_W - DATA_W + 1;

  typedef enum logic [1:0] {IDLE, LOAD, MAC, HOLD} state_e;

  state_e                    state_q, state_d;
  logic                      mode_q, mode_d;
  logic [LW-1:0]             ld_q, ld_d;
  logic [IW-1:0]             row_q, row_d;
  logic [IW-1:0]             col_q, col_d;
  logic [IW-1:0]             k_q, k_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [DATA_W-1:0]         out_q, out_d;
  logic                      done_q, done_d;

  logic signed [DATA_W-1:0]  a_mem [NN];
  logic signed [DATA_W-1:0]  b_mem [NN];

  logic [LW-1:0]             ld_last;
  logic [AW-1:0]             b_wr;
  logic [AW-1:0]             a_addr, b_addr;
  logic signed [DATA_W-1:0]  a_op, b_op;
  logic signed [PW-1:0]      prod;
  logic signed [ACC_W-1:0]   acc_base, acc_sum;
  logic                      k_last;
  logic                      last_idx_col, last_idx_row;
  logic [DATA_W-1:0]         res;

  assign ld_last = mode_q ? LW'(NN - 1) : LW'(2 * NN - 1);
  assign b_wr    = AW'(ld_q - LW'(NN));

  // Operand buffers carry no reset so an aborted job leaves them intact.
  always_ff @(posedge clk_mul) begin
    if (!rst_mul && state_q == LOAD && bus.in_valid) begin
      if (ld_q < LW'(NN)) begin
        a_mem[ld_q[AW-1:0]] <= bus.in_data;
      end else begin
        b_mem[b_wr] <= bus.in_data;
      end
    end
  end

  assign a_addr = AW'(row_q) * AW'(N) + AW'(k_q);
  assign b_addr = AW'(k_q) * AW'(N) + AW'(col_q);
  assign a_op   = a_mem[a_addr];
  assign b_op   = mode_q ? a_mem[b_addr] : b_mem[b_addr];
  assign prod   = a_op * b_op;

  assign k_last       = (k_q == IW'(N - 1));
  assign last_idx_col = (col_q == IW'(N - 1));
  assign last_idx_row = (row_q == IW'(N - 1));

  assign acc_base = (k_q == '0) ? '0 : acc_q;
  assign acc_sum  = acc_base + {{(ACC_W - PW){prod[PW-1]}}, prod};

`ifdef MAT_SQ_SAT_EN
  logic sat_hit;
  logic ovf_q, ovf_d;

  // Result fits only when every bit above the kept window matches its sign bit.
  always_comb begin
    res     = acc_sum[FRAC_W+DATA_W-1:FRAC_W];
    sat_hit = 1'b0;
    if (acc_sum[ACC_W-1:FRAC_W+DATA_W-1] != {HI_W{acc_sum[ACC_W-1]}}) begin
      sat_hit = 1'b1;
      res     = acc_sum[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                 : {1'b0, {(DATA_W-1){1'b1}}};
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    if (state_q == IDLE && bus.start) begin
      ovf_d = 1'b0;
    end else if (state_q == MAC && k_last && sat_hit) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk_mul) begin
    if (rst_mul) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign bus.ovf = ovf_q;
`else
  assign res     = acc_sum[FRAC_W+DATA_W-1:FRAC_W];
  assign bus.ovf = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    ld_d    = ld_q;
    row_d   = row_q;
    col_d   = col_q;
    k_d     = k_q;
    acc_d   = acc_q;
    out_d   = out_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = LOAD;
          mode_d  = bus.mode_sq;
          ld_d    = '0;
          row_d   = '0;
          col_d   = '0;
          k_d     = '0;
        end
      end
      LOAD: begin
        if (bus.in_valid) begin
          if (ld_q == ld_last) begin
            state_d = MAC;
            ld_d    = '0;
          end else begin
            ld_d = ld_q + 1'b1;
          end
        end
      end
      MAC: begin
        acc_d = acc_sum;
        if (k_last) begin
          k_d     = '0;
          out_d   = res;
          state_d = HOLD;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_d = MAC;
          if (last_idx_col) begin
            col_d = '0;
            if (last_idx_row) begin
              row_d   = '0;
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_mul) begin
    if (rst_mul) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      ld_q    <= '0;
      row_q   <= '0;
      col_q   <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      ld_q    <= ld_d;
      row_q   <= row_d;
      col_q   <= col_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

  assign bus.in_ready  = (state_q == LOAD);
  assign bus.out_valid = (state_q == HOLD);
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;
  assign bus.out_data  = out_q;

endmodule

// File: tb/tb_mat_sq_seq.sv
// Directed jobs against a reference matrix model; expected results are queued at job start
// and popped on each accepted output.
module tb_mat_sq_seq;
  localparam int N  = 4;
  localparam int DW = 26;
  localparam int FW = 13;
  localparam int NN = N * N;

  logic clk_mul = 1'b0;
  logic rst_mul;
  always #5 clk_mul = ~clk_mul;

  mat_sq_seq_if #(.DATA_W(DW)) bus ();

  mat_sq_seq #(.N(N), .DATA_W(DW), .FRAC_W(FW)) dut (
    .clk_mul (clk_mul),
    .rst_mul (rst_mul),
    .bus     (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;
  longint a_m [NN];
  longint b_m [NN];
  logic signed [63:0] sb_q [$];

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  function automatic longint model(input int r, input int c, input bit mode, output bit sat);
    longint acc, sh, lim;
`ifndef MAT_SQ_SAT_EN
    longint w;
`endif
    acc = 0;
    for (int k = 0; k < N; k++)
      acc += a_m[r*N+k] * (mode ? a_m[k*N+c] : b_m[k*N+c]);
    sh  = acc >>> FW;
    sat = 1'b0;
    lim = 64'sd1 <<< (DW - 1);
`ifdef MAT_SQ_SAT_EN
    if (sh > lim - 1) begin sat = 1'b1; return lim - 1; end
    if (sh < -lim)    begin sat = 1'b1; return -lim;    end
    return sh;
`else
    w = sh & ((lim <<< 1) - 1);
    if (w >= lim) w -= (lim <<< 1);
    return w;
`endif
  endfunction

  task automatic run_job(input string tag, input bit mode, input int rdy_pct, input int gap_pct,
                         input int abort_mac, input bit pre_started, input bit chain, input bit chain_mode);
    int ld_tot, ld_idx, outs, cyc, mac_cyc, bad, done_cyc;
    bit held, fin, sat, any_sat;
    logic [DW-1:0] held_val;
    logic signed [63:0] e;
    ld_tot = mode ? NN : 2 * NN;
    ld_idx = 0; outs = 0; cyc = 0; mac_cyc = -1; done_cyc = -1;
    held = 1'b0; fin = 1'b0; any_sat = 1'b0; held_val = '0;
    if (abort_mac == 0) begin
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++) begin
          e = model(r, c, mode, sat);
          any_sat |= sat;
          sb_q.push_back(e);
        end
    end
    if (!pre_started) begin
      @(posedge clk_mul); #1;
      bus.start = 1'b1; bus.mode_sq = mode;
      @(posedge clk_mul); #1;
      bus.start = 1'b0;
    end
    chk({tag, " busy_at_start"}, bus.busy, 1);
    chk({tag, " ovf_cleared"}, bus.ovf, 0);
    while (!fin && cyc < 3000) begin
      if (mac_cyc >= 0) mac_cyc++;
      if (abort_mac > 0 && mac_cyc == abort_mac) begin
        rst_mul = 1'b1; bus.start = 1'b1; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        @(posedge clk_mul); #1;
        rst_mul = 1'b0; bus.start = 1'b0; bus.in_valid = 1'b0;
        chk({tag, " busy_after_rst"}, bus.busy, 0);
        chk({tag, " out_valid_after_rst"}, bus.out_valid, 0);
        chk({tag, " done_after_rst"}, bus.done, 0);
        bad = 0;
        repeat (NN * (N + 1)) begin
          @(posedge clk_mul); #1;
          if (bus.out_valid || bus.done || bus.busy) bad++;
        end
        chk({tag, " quiet_after_abort"}, bad, 0);
        return;
      end
      if (bus.done) begin
        done_cyc = cyc;
        fin = 1'b1;
        chk({tag, " busy_low_at_done"}, bus.busy, 0);
        chk({tag, " outputs_at_done"}, outs, NN);
        chk({tag, " ovf_at_done"}, bus.ovf, any_sat);
        bus.start = chain; bus.mode_sq = chain_mode;
      end else begin
        bus.start   = bus.busy ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.mode_sq = 1'($urandom_range(0, 1));
      end
      if (bus.out_valid) begin
        if (held) chk({tag, " hold_stable"}, bus.out_data, held_val);
        bus.out_ready = ($urandom_range(0, 99) < rdy_pct);
        if (bus.out_ready) begin
          e = (sb_q.size() > 0) ? sb_q.pop_front() : 'x;
          chk({tag, " out_data"}, $signed(bus.out_data), e);
          outs++;
          held = 1'b0;
        end else begin
          held = 1'b1;
          held_val = bus.out_data;
        end
      end else begin
        bus.out_ready = 1'($urandom_range(0, 1));
      end
      if (bus.in_ready && ld_idx < ld_tot) begin
        bus.in_valid = ($urandom_range(0, 99) >= gap_pct);
        bus.in_data  = (ld_idx < NN) ? a_m[ld_idx][DW-1:0] : b_m[ld_idx-NN][DW-1:0];
        if (bus.in_valid) begin
          ld_idx++;
          if (ld_idx == ld_tot) mac_cyc = 0;
        end
      end else begin
        bus.in_valid = 1'($urandom_range(0, 1));
        bus.in_data  = DW'($urandom);
      end
      @(posedge clk_mul); #1;
      cyc++;
    end
    bus.start = 1'b0;
    chk({tag, " finished"}, fin, 1);
    chk({tag, " single_done"}, bus.done, 0);
    if (rdy_pct == 100 && gap_pct == 0)
      chk({tag, " cycles"}, done_cyc, ld_tot + NN * (N + 1));
  endtask

  initial begin
    rst_mul = 1'b1;
    bus.start = 1'b0; bus.mode_sq = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    repeat (2) @(posedge clk_mul);
    #1;
    chk("rst in_ready", bus.in_ready, 0);
    chk("rst out_valid", bus.out_valid, 0);
    chk("rst busy", bus.busy, 0);
    chk("rst done", bus.done, 0);
    chk("rst ovf", bus.ovf, 0);
    chk("rst out_data", bus.out_data, 0);
    bus.start = 1'b1;
    @(posedge clk_mul); #1;
    chk("rst beats start", bus.busy, 0);
    rst_mul = 1'b0; bus.start = 1'b0;

    for (int i = 0; i < NN; i++) a_m[i] = (i / N == i % N) ? 8192 : 0;
    run_job("ident", 1'b1, 100, 0, 0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < NN; i++) a_m[i] = 16384;
    run_job("two", 1'b1, 100, 0, 0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < NN; i++) begin
      a_m[i] = 8192;
      b_m[i] = (i / N == i % N) ? 8192 * (i % N + 1) : 0;
    end
    run_job("diagB", 1'b0, 100, 0, 0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < NN; i++) begin
      a_m[i] = longint'($urandom_range(0, 262144)) - 64'sd131072;
      b_m[i] = longint'($urandom_range(0, 262144)) - 64'sd131072;
    end
    run_job("rnd0", 1'b0, 30, 30, 0, 1'b0, 1'b0, 1'b0);
    run_job("rnd1", 1'b1, 30, 30, 0, 1'b0, 1'b0, 1'b0);

    run_job("abort", 1'b1, 100, 0, 3, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < NN; i++) a_m[i] = 8192;
    run_job("ones", 1'b1, 100, 0, 0, 1'b0, 1'b1, 1'b1);

    for (int i = 0; i < NN; i++) a_m[i] = 64'sd1 <<< 24;
    run_job("big", 1'b1, 30, 20, 0, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < NN; i++) a_m[i] = (i / N == i % N) ? 8192 : 0;
    run_job("ident2", 1'b1, 100, 0, 0, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
